quad_decoder_array: RTL and testbench



---
 rtl/quad_decoder_array.sv | 196 +++++++++++++++++++
 tb/tb_quad_decoder_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_array.sv
// Multi-channel quadrature decoder: per-pin sync + glitch filter, 4x decode,
// detent divider and clamped/wrapping position with synchronous preset.

module qd_pin_filter #(
   parameter int FILTER = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filt
);
   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // Counter only runs while synced and filtered disagree; any agreement restarts it.
   always_comb begin
      sync_d = {sync_q[0], raw};
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER - 1)) filt_d = sync_q[1];
         else                          cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;
endmodule

module qd_lane #(
   parameter int WIDTH           = 8,
   parameter int INCREMENT       = 1,
   parameter int FILTER          = 3,
   parameter int COUNTS_PER_STEP = 4,
   parameter int MIN_VAL         = 0,
   parameter int MAX_VAL         = 255,
   parameter int WRAP            = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             error_clear,
   output logic [WIDTH-1:0] value,
   output logic             step_pulse,
   output logic             step_dir,
   output logic             error
);
   localparam int W1    = WIDTH + 1;
   localparam int ACC_W = $clog2(COUNTS_PER_STEP) + 2;
   localparam logic [WIDTH:0] MIN_E = W1'(MIN_VAL);
   localparam logic [WIDTH:0] MAX_E = W1'(MAX_VAL);
   localparam logic [WIDTH:0] INC_E = W1'(INCREMENT);
   localparam logic signed [ACC_W-1:0] CPS_S = ACC_W'(COUNTS_PER_STEP);
   localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

   logic             fa, fb;
   logic [1:0]       prev_q, prev_d, cur_idx, prev_idx, dlt;
   logic             fwd, rev, ill, up, dn;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_n;
   logic [WIDTH-1:0] value_q, value_d, up_v, dn_v, ld_v;
   logic [WIDTH:0]   v_e, sum_e, lv_e;
   logic             pulse_q, pulse_d, dir_q, dir_d, err_q, err_d;

   qd_pin_filter #(.FILTER(FILTER)) u_fa (.clk(clk), .reset(reset), .raw(enc_a), .filt(fa));
   qd_pin_filter #(.FILTER(FILTER)) u_fb (.clk(clk), .reset(reset), .raw(enc_b), .filt(fb));

   always_comb begin
      // Gray {A,B} to position 0..3; the mod-4 difference classifies the move.
      cur_idx  = {fa, fa ^ fb};
      prev_idx = {prev_q[1], prev_q[1] ^ prev_q[0]};
      dlt      = cur_idx - prev_idx;
      fwd      = (dlt == 2'b01);
      rev      = (dlt == 2'b11);
      ill      = (dlt == 2'b10);
      prev_d   = {fa, fb};

      acc_n = acc_q;
      if (fwd)      acc_n = acc_q + ONE;
      else if (rev) acc_n = acc_q - ONE;
      up = (acc_n == CPS_S);
      dn = (acc_n == -CPS_S);

      v_e   = {1'b0, value_q};
      sum_e = v_e + INC_E;
      up_v  = (sum_e <= MAX_E) ? sum_e[WIDTH-1:0]
            : ((WRAP != 0) ? MIN_E[WIDTH-1:0] : MAX_E[WIDTH-1:0]);
      dn_v  = (v_e >= MIN_E + INC_E) ? (value_q - INC_E[WIDTH-1:0])
            : ((WRAP != 0) ? MAX_E[WIDTH-1:0] : MIN_E[WIDTH-1:0]);

      lv_e = {1'b0, load_value};
      if (lv_e < MIN_E)      ld_v = MIN_E[WIDTH-1:0];
      else if (lv_e > MAX_E) ld_v = MAX_E[WIDTH-1:0];
      else                   ld_v = load_value;

      value_d = value_q;
      acc_d   = acc_n;
      pulse_d = 1'b0;
      dir_d   = dir_q;
      err_d   = ill | (err_q & ~error_clear);
      if (load) begin
         value_d = ld_v;
         acc_d   = '0;
      end else if (up) begin
         value_d = up_v;
         acc_d   = '0;
         pulse_d = 1'b1;
         dir_d   = 1'b1;
      end else if (dn) begin
         value_d = dn_v;
         acc_d   = '0;
         pulse_d = 1'b1;
         dir_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q  <= '0;
         acc_q   <= '0;
         value_q <= MIN_E[WIDTH-1:0];
         pulse_q <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         pulse_q <= pulse_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   assign value      = value_q;
   assign step_pulse = pulse_q;
   assign step_dir   = dir_q;
   assign error      = err_q;
endmodule

module quad_decoder_array #(
   parameter int CHANNELS        = 2,
   parameter int WIDTH           = 8,
   parameter int INCREMENT       = 1,
   parameter int FILTER          = 3,
   parameter int COUNTS_PER_STEP = 4,
   parameter int MIN_VAL         = 0,
   parameter int MAX_VAL         = 2**WIDTH - 1,
   parameter int WRAP            = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       enc_a,
   input  logic [CHANNELS-1:0]       enc_b,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_value,
   input  logic [CHANNELS-1:0]       error_clear,
   output logic [CHANNELS*WIDTH-1:0] value,
   output logic [CHANNELS-1:0]       step_pulse,
   output logic [CHANNELS-1:0]       step_dir,
   output logic [CHANNELS-1:0]       error
);
   logic [CHANNELS-1:0][WIDTH-1:0] ld_arr, val_arr;

   assign ld_arr = load_value;
   assign value  = val_arr;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      qd_lane #(
         .WIDTH(WIDTH), .INCREMENT(INCREMENT), .FILTER(FILTER),
         .COUNTS_PER_STEP(COUNTS_PER_STEP), .MIN_VAL(MIN_VAL),
         .MAX_VAL(MAX_VAL), .WRAP(WRAP)
      ) u_lane (
         .clk(clk), .reset(reset), .enc_a(enc_a[i]), .enc_b(enc_b[i]),
         .load(load[i]), .load_value(ld_arr[i]), .error_clear(error_clear[i]),
         .value(val_arr[i]), .step_pulse(step_pulse[i]),
         .step_dir(step_dir[i]), .error(error[i])
      );
   end
endmodule

// File: tb/tb_quad_decoder_array.sv
// Scoreboard bench: three differently-parameterised instances share the encoder
// pins; a transition-level model predicts steps, a negedge monitor checks them.

module tb_quad_decoder_array;
   localparam int FILT = 3;
   localparam int LAT  = FILT + 3;

   typedef struct {int v; bit dir; int due;} exp_t;

   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  enc_a = '0, enc_b = '0, err_clr = '0;
   logic [1:0]  ld0 = '0, ld1 = '0, ld2 = '0;
   logic [15:0] lv0 = '0, val0;
   logic [7:0]  lv1 = '0, val1;
   logic [9:0]  lv2 = '0, val2;
   logic [1:0]  sp0, sp1, sp2, sd0, sd1, sd2, er0, er1, er2;

   quad_decoder_array #(.CHANNELS(2), .WIDTH(8), .INCREMENT(1), .FILTER(FILT),
      .COUNTS_PER_STEP(4), .MIN_VAL(0), .MAX_VAL(200), .WRAP(0)) dut0 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(ld0),
      .load_value(lv0), .error_clear(err_clr), .value(val0),
      .step_pulse(sp0), .step_dir(sd0), .error(er0));
   quad_decoder_array #(.CHANNELS(2), .WIDTH(4), .INCREMENT(3), .FILTER(FILT),
      .COUNTS_PER_STEP(1), .MIN_VAL(0), .MAX_VAL(10), .WRAP(0)) dut1 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(ld1),
      .load_value(lv1), .error_clear(err_clr), .value(val1),
      .step_pulse(sp1), .step_dir(sd1), .error(er1));
   quad_decoder_array #(.CHANNELS(2), .WIDTH(5), .INCREMENT(4), .FILTER(FILT),
      .COUNTS_PER_STEP(2), .MIN_VAL(5), .MAX_VAL(20), .WRAP(1)) dut2 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(ld2),
      .load_value(lv2), .error_clear(err_clr), .value(val2),
      .step_pulse(sp2), .step_dir(sd2), .error(er2));

   int inc_p[3]  = '{1, 3, 4};
   int cps_p[3]  = '{4, 1, 2};
   int min_p[3]  = '{0, 0, 5};
   int max_p[3]  = '{200, 10, 20};
   int wrap_p[3] = '{0, 0, 1};

   // index i = dut*2 + channel
   int   ov[6];
   bit   op[6], od[6], oe[6];
   int   mval[6], macc[6], npulse[6];
   bit   mdir[6], merr[6];
   exp_t sb[6][$];
   exp_t mon_e;
   int   cyc = 0, errs = 0, checks = 0;

   always_comb begin
      ov[0] = int'(val0[7:0]);  ov[1] = int'(val0[15:8]);
      ov[2] = int'(val1[3:0]);  ov[3] = int'(val1[7:4]);
      ov[4] = int'(val2[4:0]);  ov[5] = int'(val2[9:5]);
      op[0] = sp0[0]; op[1] = sp0[1]; op[2] = sp1[0]; op[3] = sp1[1]; op[4] = sp2[0]; op[5] = sp2[1];
      od[0] = sd0[0]; od[1] = sd0[1]; od[2] = sd1[0]; od[3] = sd1[1]; od[4] = sd2[0]; od[5] = sd2[1];
      oe[0] = er0[0]; oe[1] = er0[1]; oe[2] = er1[0]; oe[3] = er1[1]; oe[4] = er2[0]; oe[5] = er2[1];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 6; i++) begin
            if (op[i]) begin
               npulse[i]++;
               checks++;
               if (sb[i].size() == 0) begin
                  errs++;
                  $display("FAIL spurious_step idx=%0d got value=%0d dir=%0d cyc=%0d, none expected",
                           i, ov[i], od[i], cyc);
               end else begin
                  mon_e = sb[i].pop_front();
                  if (ov[i] != mon_e.v || od[i] != mon_e.dir || cyc != mon_e.due) begin
                     errs++;
                     $display("FAIL step idx=%0d got value=%0d dir=%0d cyc=%0d want value=%0d dir=%0d cyc=%0d",
                              i, ov[i], od[i], cyc, mon_e.v, mon_e.dir, mon_e.due);
                  end
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   function automatic int gidx(input logic a, input logic b);
      return b ? (a ? 2 : 1) : (a ? 3 : 0);
   endfunction

   function automatic bit [1:0] gab(input int idx);
      case (idx)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int clampv(input int d, input int v);
      if (v < min_p[d]) return min_p[d];
      if (v > max_p[d]) return max_p[d];
      return v;
   endfunction

   function automatic int stepv(input int d, input int v, input bit up);
      if (up) return (v + inc_p[d] <= max_p[d]) ? v + inc_p[d] : ((wrap_p[d] != 0) ? min_p[d] : max_p[d]);
      return (v - inc_p[d] >= min_p[d]) ? v - inc_p[d] : ((wrap_p[d] != 0) ? max_p[d] : min_p[d]);
   endfunction

   // Drive a new gray position on channel ch and predict its effect.
   // ld0v >= 0 loads dut0 and clr pulses error_clear on the edge the move lands.
   task automatic xfer(input int ch, input int nidx, input int ld0v = -1, input bit clr = 1'b0);
      int dl;
      bit [1:0] ab;
      exp_t e;
      dl = (nidx - gidx(enc_a[ch], enc_b[ch]) + 4) % 4;
      ab = gab(nidx);
      enc_a[ch] = ab[1];
      enc_b[ch] = ab[0];
      for (int d = 0; d < 3; d++) begin
         int i;
         bit st, up;
         i = d * 2 + ch; st = 1'b0; up = 1'b0;
         if (dl == 2) merr[i] = 1'b1;
         else if (clr) merr[i] = 1'b0;
         if (dl == 1 || dl == 3) begin
            macc[i] += (dl == 1) ? 1 : -1;
            if (macc[i] == cps_p[d]) begin st = 1'b1; up = 1'b1; macc[i] = 0; end
            else if (macc[i] == -cps_p[d]) begin st = 1'b1; macc[i] = 0; end
         end
         if (d == 0 && ld0v >= 0) begin
            mval[i] = clampv(0, ld0v);
            macc[i] = 0;
         end else if (st) begin
            mval[i] = stepv(d, mval[i], up);
            mdir[i] = up;
            e.v = mval[i]; e.dir = up; e.due = cyc + LAT;
            sb[i].push_back(e);
         end
      end
      if (ld0v >= 0 || clr) begin
         tick(FILT + 2);
         if (ld0v >= 0) begin ld0[ch] = 1'b1; lv0[ch*8 +: 8] = 8'(ld0v); end
         if (clr) err_clr[ch] = 1'b1;
         tick(1);
         ld0 = '0; err_clr = '0;
      end
   endtask

   task automatic fwd(input int ch, input int hold = FILT + 2);
      xfer(ch, (gidx(enc_a[ch], enc_b[ch]) + 1) % 4);
      tick(hold);
   endtask

   task automatic rev(input int ch, input int hold = FILT + 2);
      xfer(ch, (gidx(enc_a[ch], enc_b[ch]) + 3) % 4);
      tick(hold);
   endtask

   task automatic load_q(input int d, input int ch, input int v);
      tick(LAT);
      case (d)
         0: begin ld0[ch] = 1'b1; lv0[ch*8 +: 8] = 8'(v); end
         1: begin ld1[ch] = 1'b1; lv1[ch*4 +: 4] = 4'(v); end
         default: begin ld2[ch] = 1'b1; lv2[ch*5 +: 5] = 5'(v); end
      endcase
      tick(1);
      ld0 = '0; ld1 = '0; ld2 = '0;
      mval[d*2+ch] = clampv(d, v);
      macc[d*2+ch] = 0;
   endtask

   task automatic clear_q(input int ch);
      tick(LAT);
      err_clr[ch] = 1'b1;
      tick(1);
      err_clr = '0;
      for (int d = 0; d < 3; d++) merr[d*2+ch] = 1'b0;
   endtask

   initial begin
      int np;
      tick(3);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rst_value%0d", i), ov[i], min_p[i/2]);
         chk($sformatf("rst_flags%0d", i), int'(op[i] | od[i] | oe[i]), 0);
         mval[i] = min_p[i/2]; macc[i] = 0; mdir[i] = 1'b0; merr[i] = 1'b0;
      end
      reset = 1'b0;
      tick(2);

      // Forward rotation: 8 full gray cycles on ch0.
      for (int k = 0; k < 32; k++) fwd(0, FILT + 2 + $urandom_range(2, 0));
      tick(LAT);
      chk("fwd_val0", ov[0], 8);
      chk("fwd_val1", ov[1], 0);
      chk("fwd_pulses", npulse[0], 8);
      chk("fwd_err", int'(oe[0]), 0);

      // Saturation on dut1 (INC=3, MAX=10, one count per step).
      load_q(1, 0, 9);
      fwd(0, LAT + 1);  chk("sat_up1", ov[2], 10);
      fwd(0, LAT + 1);  chk("sat_up2", ov[2], 10);
      load_q(1, 0, 2);
      rev(0, LAT + 1);  chk("sat_dn", ov[2], 0);

      // Wrap on dut2 (MIN=5, MAX=20, INC=4, two counts per step).
      load_q(2, 0, 18);
      fwd(0); fwd(0, LAT + 1); chk("wrap_up", ov[4], 5);
      rev(0); rev(0, LAT + 1); chk("wrap_dn", ov[4], 20);

      // Glitch filter on ch1: 2-cycle pulse rejected, 4-cycle pulse accepted.
      np = npulse[3];
      enc_a[1] = ~enc_a[1]; tick(2); enc_a[1] = ~enc_a[1];
      tick(LAT + 4);
      chk("glitch2_pulses", npulse[3], np);
      chk("glitch2_val", ov[3], mval[3]);
      xfer(1, gidx(~enc_a[1], enc_b[1]));
      tick(4);
      xfer(1, gidx(~enc_a[1], enc_b[1]));
      tick(LAT + 2);
      chk("glitch4_pulses", npulse[3], np + 2);
      chk("glitch4_val", ov[3], mval[3]);

      // Illegal transition, clear, then set and clear together.
      xfer(1, (gidx(enc_a[1], enc_b[1]) + 2) % 4);
      tick(LAT + 1);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("ill_err%0d", d), int'(oe[d*2+1]), 1);
         chk($sformatf("ill_val%0d", d), ov[d*2+1], mval[d*2+1]);
      end
      clear_q(1);
      tick(1);
      for (int d = 0; d < 3; d++) chk($sformatf("clr_err%0d", d), int'(oe[d*2+1]), 0);
      xfer(1, (gidx(enc_a[1], enc_b[1]) + 2) % 4, -1, 1'b1);
      tick(2);
      for (int d = 0; d < 3; d++) chk($sformatf("setwins_err%0d", d), int'(oe[d*2+1]), 1);
      clear_q(1);

      // Load priority and clamp on dut0 ch0.
      load_q(0, 0, 100);
      fwd(0); fwd(0); fwd(0);
      np = npulse[0];
      xfer(0, (gidx(enc_a[0], enc_b[0]) + 1) % 4, 250);
      tick(LAT);
      chk("ldpri_val", ov[0], 200);
      chk("ldpri_nopulse", npulse[0], np);
      fwd(0); fwd(0); fwd(0, LAT + 1);
      chk("ldpri_3cnt", npulse[0], np);
      fwd(0, LAT + 1);
      chk("ldpri_4cnt", npulse[0], np + 1);
      chk("ldpri_sat", ov[0], 200);

      // Randomised walk with occasional loads, illegal jumps and clears.
      for (int it = 0; it < 200; it++) begin
         int ch, r, d;
         ch = $urandom_range(1, 0);
         r  = $urandom_range(19, 0);
         if (r == 0)      xfer(ch, (gidx(enc_a[ch], enc_b[ch]) + 2) % 4);
         else if (r == 1) clear_q(ch);
         else if (r <= 3) begin
            d = $urandom_range(2, 0);
            load_q(d, ch, (d == 0) ? $urandom_range(255, 0) : (d == 1) ? $urandom_range(15, 0) : $urandom_range(31, 0));
         end
         else if (r % 2 == 1) xfer(ch, (gidx(enc_a[ch], enc_b[ch]) + 1) % 4);
         else                 xfer(ch, (gidx(enc_a[ch], enc_b[ch]) + 3) % 4);
         tick(FILT + 2 + $urandom_range(3, 0));
      end
      tick(LAT + 4);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("final_val%0d", i), ov[i], mval[i]);
         chk($sformatf("final_err%0d", i), int'(oe[i]), int'(merr[i]));
         chk($sformatf("sb_empty%0d", i), sb[i].size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      errs++;
      checks++;
      $display("FAIL timeout got cyc=%0d want finish before limit", cyc);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
